// File: rtl/arm_mc_pkg.sv
// Shared types and constants for the multicycle LDM/STM block-transfer path.
// Provides the sequencer state enum, PC index, word stride and a popcount helper.
package arm_mc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    localparam logic [3:0] REG_PC     = 4'd15;
    localparam int         WORD_BYTES = 4;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/lowbit_enc.sv
// Priority encoder: index of the lowest set bit of a 16-bit vector.
// Ports: vec_i (list), idx_o (lowest set index, 0 if none), valid_o (any bit set).
module lowbit_enc (
    input  logic [15:0] vec_i,
    output logic [3:0]  idx_o,
    output logic        valid_o
);

    always_comb begin
        idx_o = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = 4'(i);
            end
        end
    end

    assign valid_o = |vec_i;

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM sequencer: walks a register list, one memory word per beat,
// then optionally writes the final address back to the base register.
// Ports: clk, reset (async active-low); start/load/up/pre/wback/rn/base/reglist
// command; busy/done status; rf_ra/rf_rd store read; rf_we4/wa4/wd4 load write;
// rf_we3/wa3/wd3 base writeback; pc_we/pc_wd load to R15; mem_* beat handshake.
module ldm_stm_sequencer
    import arm_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             load,
    input  logic             up,
    input  logic             pre,
    input  logic             wback,
    input  logic [3:0]       rn,
    input  logic [WIDTH-1:0] base,
    input  logic [15:0]      reglist,
    output logic             busy,
    output logic             done,
    output logic [3:0]       rf_ra,
    input  logic [WIDTH-1:0] rf_rd,
    output logic             rf_we4,
    output logic [3:0]       rf_wa4,
    output logic [WIDTH-1:0] rf_wd4,
    output logic             rf_we3,
    output logic [3:0]       rf_wa3,
    output logic [WIDTH-1:0] rf_wd3,
    output logic             pc_we,
    output logic [WIDTH-1:0] pc_wd,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready
);

    localparam logic [WIDTH-1:0] STRIDE = WIDTH'(WORD_BYTES);

    seq_state_t       state_q;
    logic [15:0]      list_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] final_q;
    logic             load_q;
    logic             wben_q;
    logic [3:0]       rn_q;

    logic [3:0]       cur_idx;
    logic             cur_vld;
    logic [15:0]      rest;
    logic [WIDTH-1:0] span;
    logic [WIDTH-1:0] first_d;
    logic [WIDTH-1:0] final_d;
    logic             beat;
    logic             in_xfer;
    logic             st_xfer;
    logic             ld_beat;
    logic             is_pc;

    lowbit_enc u_enc (
        .vec_i   (list_q),
        .idx_o   (cur_idx),
        .valid_o (cur_vld)
    );

    // List with the current register removed; empty means this is the last beat.
    assign rest = list_q & ~(16'(1) << cur_idx);

    // Lowest register always sits at the lowest address, so decrementing
    // modes start at the bottom of the block and still count upwards.
    assign span    = WIDTH'({popcount16(reglist), 2'b00});
    assign final_d = up ? base + span : base - span;
    always_comb begin
        first_d = base;
        unique case (1'b1)
            up && pre:   first_d = base + STRIDE;
            up && !pre:  first_d = base;
            !up && pre:  first_d = base - span;
            !up && !pre: first_d = base - span + STRIDE;
            default:     first_d = base;
        endcase
    end

    assign in_xfer = (state_q == XFER);
    assign beat    = in_xfer && mem_ready && cur_vld;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            list_q  <= '0;
            addr_q  <= '0;
            final_q <= '0;
            load_q  <= 1'b0;
            wben_q  <= 1'b0;
            rn_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        list_q  <= reglist;
                        addr_q  <= first_d;
                        final_q <= final_d;
                        load_q  <= load;
                        rn_q    <= rn;
                        // A loaded base value beats the writeback.
                        wben_q  <= wback && (|reglist) && !(load && reglist[rn]);
                        // An empty list still passes through WB (with
                        // writeback off) so done lands two cycles after start.
                        state_q <= (reglist == '0) ? WB : XFER;
                    end
                end
                XFER: begin
                    if (beat) begin
                        list_q <= rest;
                        addr_q <= addr_q + STRIDE;
                        if (rest == '0) begin
                            state_q <= WB;
                        end
                    end
                end
                WB:      state_q <= DONE;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign st_xfer = in_xfer && !load_q;
    assign ld_beat = beat && load_q;
    assign is_pc   = (cur_idx == REG_PC);

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign mem_req   = in_xfer;
    assign mem_we    = st_xfer;
    assign mem_addr  = in_xfer ? addr_q : '0;
    assign rf_ra     = st_xfer ? cur_idx : '0;
    assign mem_wdata = st_xfer ? rf_rd : '0;

    assign rf_we4 = ld_beat && !is_pc;
    assign rf_wa4 = rf_we4 ? cur_idx : '0;
    assign rf_wd4 = rf_we4 ? mem_rdata : '0;
    assign pc_we  = ld_beat && is_pc;
    assign pc_wd  = pc_we ? mem_rdata : '0;

    assign rf_we3 = (state_q == WB) && wben_q;
    assign rf_wa3 = rf_we3 ? rn_q : '0;
    assign rf_wd3 = rf_we3 ? final_q : '0;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Self-checking bench for ldm_stm_sequencer: directed table plus random
// transfers checked against a list/address model of block transfers.
module tb_ldm_stm_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, load, up, pre, wback;
    logic [3:0]  rn;
    logic [31:0] base;
    logic [15:0] reglist;
    logic        busy, done;
    logic [3:0]  rf_ra;
    logic [31:0] rf_rd;
    logic        rf_we4;
    logic [3:0]  rf_wa4;
    logic [31:0] rf_wd4;
    logic        rf_we3;
    logic [3:0]  rf_wa3;
    logic [31:0] rf_wd3;
    logic        pc_we;
    logic [31:0] pc_wd;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A00_0000;
    endfunction

    function automatic logic [31:0] regfn(input logic [3:0] r);
        return 32'hC0DE_0000 | (32'(r) * 32'h111);
    endfunction

    assign rf_rd     = regfn(rf_ra);
    assign mem_rdata = memfn(mem_addr);

    ldm_stm_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .load(load), .up(up),
        .pre(pre), .wback(wback), .rn(rn), .base(base), .reglist(reglist),
        .busy(busy), .done(done), .rf_ra(rf_ra), .rf_rd(rf_rd),
        .rf_we4(rf_we4), .rf_wa4(rf_wa4), .rf_wd4(rf_wd4),
        .rf_we3(rf_we3), .rf_wa3(rf_wa3), .rf_wd3(rf_wd3),
        .pc_we(pc_we), .pc_wd(pc_wd), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    int checks = 0;
    int errors = 0;

    // Observed-activity record for the transfer in flight.
    bit          mon_en = 1'b0;
    logic [31:0] b_addr[$];
    logic [31:0] b_data[$];
    logic [3:0]  b_reg[$];
    bit          b_we[$];
    int          wb_n, stalls, spurious, lat, done_lat;
    logic [3:0]  wb_rn;
    logic [31:0] wb_val;
    bit          done_seen, prev_stall, prev_we;
    logic [31:0] prev_addr;
    int          rmode = 0;
    int          stall_left = 0;

    always @(posedge clk) begin
        #1;
        case (rmode)
            1: mem_ready = ($urandom_range(0, 3) != 0);
            2: begin
                if (b_addr.size() == 1 && stall_left > 0) begin
                    mem_ready = 1'b0;
                    stall_left--;
                end else begin
                    mem_ready = 1'b1;
                end
            end
            default: mem_ready = 1'b1;
        endcase
    end

    always @(negedge clk) begin
        if (mon_en) begin
            lat++;
            if ((rf_we4 || pc_we) && !(mem_req && mem_ready)) spurious++;
            if (mem_req) begin
                if (prev_stall) begin
                    checks++;
                    if (mem_addr !== prev_addr || mem_we !== prev_we) begin
                        errors++;
                        $display("FAIL hold: addr %h we %b, need %h %b",
                                 mem_addr, mem_we, prev_addr, prev_we);
                    end
                end
                if (mem_ready) begin
                    b_addr.push_back(mem_addr);
                    b_we.push_back(mem_we);
                    if (mem_we) begin
                        b_reg.push_back(rf_ra);
                        b_data.push_back(mem_wdata);
                    end else begin
                        checks++;
                        if ((rf_we4 ^ pc_we) !== 1'b1) begin
                            errors++;
                            $display("FAIL ldwe: we4 %b pc_we %b, need one",
                                     rf_we4, pc_we);
                        end
                        b_reg.push_back(pc_we ? 4'd15 : rf_wa4);
                        b_data.push_back(pc_we ? pc_wd : rf_wd4);
                    end
                    prev_stall = 1'b0;
                end else begin
                    stalls++;
                    checks++;
                    if (rf_we4 || pc_we) begin
                        errors++;
                        $display("FAIL stallwe: we4 %b pc_we %b, need 0 0",
                                 rf_we4, pc_we);
                    end
                    prev_stall = 1'b1;
                    prev_addr  = mem_addr;
                    prev_we    = mem_we;
                end
            end else begin
                prev_stall = 1'b0;
            end
            if (rf_we3) begin
                wb_n++;
                wb_rn  = rf_wa3;
                wb_val = rf_wd3;
            end
            if (done && !done_seen) begin
                done_seen = 1'b1;
                done_lat  = lat;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, need %h", nm, act, exp);
        end
    endtask

    task automatic run_xfer(input bit ld, input bit u, input bit p,
                            input bit w, input logic [3:0] r,
                            input logic [31:0] b, input logic [15:0] rl,
                            input int mode);
        b_addr.delete(); b_data.delete(); b_reg.delete(); b_we.delete();
        wb_n = 0; stalls = 0; spurious = 0; lat = -1; done_lat = -1;
        done_seen = 1'b0; prev_stall = 1'b0;
        rmode = mode;
        stall_left = 3;
        @(posedge clk); #2;
        start = 1'b1; load = ld; up = u; pre = p; wback = w;
        rn = r; base = b; reglist = rl;
        mon_en = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        load = $urandom; up = $urandom; pre = $urandom; wback = $urandom;
        rn = 4'($urandom); base = $urandom; reglist = 16'($urandom);
        for (int i = 0; i < 300 && !done_seen; i++) begin
            @(negedge clk); #1;
        end
        @(negedge clk); #1;
        mon_en = 1'b0;
        rmode = 0;
        checks++;
        if (!done_seen) begin
            errors++;
            $display("FAIL timeout: done not seen, need done");
        end
    endtask

    // Compare the recorded activity against the model of the block transfer.
    task automatic check_tx(input string nm, input bit ld,
                            input logic [3:0] r, input logic [15:0] rl,
                            input logic [31:0] first, input bit wben,
                            input logic [31:0] fin, input int exp_lat);
        int          regs[$];
        logic [31:0] ea, ed;
        for (int i = 0; i < 16; i++) if (rl[i]) regs.push_back(i);
        chk({nm, " beats"}, 32'(b_addr.size()), 32'(regs.size()));
        for (int k = 0; k < regs.size() && k < b_addr.size(); k++) begin
            ea = first + 32'(4 * k);
            ed = ld ? memfn(ea) : regfn(4'(regs[k]));
            checks++;
            if (b_addr[k] !== ea || b_reg[k] !== 4'(regs[k]) ||
                b_data[k] !== ed || b_we[k] !== !ld) begin
                errors++;
                $display("FAIL %s beat%0d: a %h r%0d d %h we %b, need %h r%0d %h %b",
                         nm, k, b_addr[k], b_reg[k], b_data[k], b_we[k],
                         ea, regs[k], ed, !ld);
            end
        end
        chk({nm, " wbcnt"}, 32'(wb_n), wben ? 32'd1 : 32'd0);
        if (wben) begin
            chk({nm, " wbrn"}, 32'(wb_rn), 32'(r));
            chk({nm, " wbval"}, wb_val, fin);
        end
        chk({nm, " latency"}, 32'(done_lat), 32'(exp_lat));
        chk({nm, " spurious"}, 32'(spurious), 32'd0);
        chk({nm, " idle"}, {30'd0, busy, done}, 32'd0);
    endtask

    typedef struct {
        string       nm;
        bit          ld, u, p, w;
        logic [3:0]  r;
        logic [31:0] b;
        logic [15:0] rl;
        int          mode;
        logic [31:0] first;
        bit          wben;
        logic [31:0] fin;
        int          lat;
    } vec_t;

    vec_t tbl[8];

    task automatic check_all_zero(input string nm);
        logic [31:0] acc;
        acc = {31'd0, busy | done | rf_we4 | rf_we3 | pc_we | mem_req | mem_we}
              | mem_addr | mem_wdata | rf_wd4 | rf_wd3 | pc_wd
              | 32'(rf_ra) | 32'(rf_wa4) | 32'(rf_wa3);
        chk(nm, acc, 32'd0);
    endtask

    initial begin
        tbl[0] = '{"stmia", 0, 1, 0, 1, 4'd0, 32'h100, 16'h0016, 0,
                   32'h100, 1, 32'h10C, 5};
        tbl[1] = '{"ldmdb", 1, 0, 1, 1, 4'd13, 32'h200, 16'h8030, 0,
                   32'h1F4, 1, 32'h1F4, 5};
        tbl[2] = '{"empty", 0, 1, 0, 1, 4'd2, 32'h40, 16'h0000, 0,
                   32'h40, 0, 32'h40, 2};
        tbl[3] = '{"ldm_rn", 1, 1, 0, 1, 4'd1, 32'h300, 16'h0006, 0,
                   32'h300, 0, 32'h308, 4};
        tbl[4] = '{"stmib", 0, 1, 1, 1, 4'd3, 32'h10, 16'h8001, 0,
                   32'h14, 1, 32'h18, 4};
        tbl[5] = '{"ldmda", 1, 0, 0, 0, 4'd6, 32'h80, 16'h0180, 0,
                   32'h7C, 0, 32'h78, 4};
        tbl[6] = '{"stmdb_wrap", 0, 0, 1, 1, 4'd5, 32'h4, 16'h0007, 0,
                   32'hFFFF_FFF8, 1, 32'hFFFF_FFF8, 5};
        tbl[7] = '{"ldm_stall", 1, 1, 0, 0, 4'd0, 32'h100, 16'h000E, 2,
                   32'h100, 0, 32'h10C, 8};

        start = 0; load = 0; up = 0; pre = 0; wback = 0;
        rn = 0; base = 0; reglist = 0; mem_ready = 1'b1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset_state");
        reset = 1'b1;

        foreach (tbl[i]) begin
            run_xfer(tbl[i].ld, tbl[i].u, tbl[i].p, tbl[i].w, tbl[i].r,
                     tbl[i].b, tbl[i].rl, tbl[i].mode);
            check_tx(tbl[i].nm, tbl[i].ld, tbl[i].r, tbl[i].rl, tbl[i].first,
                     tbl[i].wben, tbl[i].fin, tbl[i].lat);
            if (tbl[i].mode == 2) chk("stall_cnt", 32'(stalls), 32'd3);
        end

        // Start while busy must be ignored.
        run_xfer(0, 1, 0, 1, 4'd0, 32'h100, 16'h0016, 0);
        @(posedge clk); #2;
        start = 1'b1; load = 1'b0; up = 1'b1; pre = 1'b0; wback = 1'b1;
        rn = 4'd7; base = 32'h900; reglist = 16'h00F0;
        @(posedge clk); #2;
        start = 1'b1; reglist = 16'hFFFF; base = 32'h0;
        @(posedge clk); #2;
        start = 1'b0;
        chk("busy_ignore_addr", mem_addr, 32'h904);
        repeat (8) @(posedge clk);
        #2;
        chk("busy_ignore_idle", {31'd0, busy}, 32'd0);

        // Reset during beat 2 of 4.
        @(posedge clk); #2;
        start = 1'b1; load = 1'b1; up = 1'b1; pre = 1'b0; wback = 1'b1;
        rn = 4'd0; base = 32'h400; reglist = 16'h001E;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #2;
        chk("pre_reset_addr", mem_addr, 32'h404);
        reset = 1'b0;
        #1;
        check_all_zero("reset_abort");
        repeat (2) @(negedge clk);
        check_all_zero("reset_hold");
        reset = 1'b1;
        run_xfer(0, 1, 0, 1, 4'd0, 32'h100, 16'h0016, 0);
        check_tx("after_reset", 0, 4'd0, 16'h0016, 32'h100, 1, 32'h10C, 5);

        // Random transfers against the block-transfer model.
        for (int t = 0; t < 30; t++) begin
            bit          ld, u, p, w;
            logic [3:0]  r;
            logic [31:0] b, first, fin;
            logic [15:0] rl;
            int          n;
            ld = $urandom; u = $urandom; p = $urandom; w = $urandom;
            r = 4'($urandom); b = $urandom; rl = 16'($urandom);
            if (t % 7 == 0) rl = 16'h0;
            if (t % 5 == 1) rl = 16'h8000 | 16'(1 << r);
            n = $countones(rl);
            fin = u ? b + 32'(4 * n) : b - 32'(4 * n);
            // Lowest address of the n-word block.
            first = u ? (p ? b + 32'd4 : b) : (p ? fin : fin + 32'd4);
            run_xfer(ld, u, p, w, r, b, rl, 1);
            check_tx("rand", ld, r, rl, first,
                     w && n > 0 && !(ld && rl[r]), fin, n + 2 + stalls);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
